// File: rtl/if_id_hold_ctrl_pkg.sv
// Shared pipeline definitions: hold-controller state encoding and the canonical NOP word.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    KILLED = 2'd2
  } hold_state_t;

  localparam logic [31:0] MIPS_NOP  = 32'h0000_0000;
  localparam int          RUN_CNT_W = 8;

endpackage

// File: rtl/if_id_hold_ctrl_if.sv
// IF/ID hold-controller bus: fetch/hazard-detector side drives requests, controller returns IF/ID contents.
interface if_id_hold_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hazard;
    logic             flush;
    logic [31:0]      if_pc4;
    logic [31:0]      if_instr;
    logic             pc_wen;
    logic             ex_bubble;
    logic [31:0]      id_pc4;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_timeout;

    // Requests are level signals sampled every cycle; there is no valid/ready
    // handshake, so hazard/flush must be stable before the rising edge.
    modport master (
        output hazard, flush, if_pc4, if_instr,
        input  pc_wen, ex_bubble, id_pc4, id_instr, id_valid,
        input  state, stall_cnt, flush_cnt, stall_timeout
    );

    modport slave (
        input  hazard, flush, if_pc4, if_instr,
        output pc_wen, ex_bubble, id_pc4, id_instr, id_valid,
        output state, stall_cnt, flush_cnt, stall_timeout
    );
endinterface

// File: rtl/if_id_hold_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/if_id_hold_ctrl.sv
// IF/ID pipeline register with stall/flush control, saturating perf counters and a stall watchdog.
module if_id_hold_ctrl
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = MIPS_NOP,
    parameter int          CNT_W     = 16,
    parameter int          MAX_STALL = 8
) (
    input logic         clk,
    input logic         rst,
    if_id_hold_ctrl_if.slave bus
);
    hold_state_t            r_state;
    hold_state_t            w_next_state;
    logic                   w_hazard;
    logic                   w_flush;
    logic                   w_pc_wen;
    logic                   w_ex_bubble;
    logic [31:0]            r_id_pc4;
    logic [31:0]            r_id_instr;
    logic                   r_id_valid;
    logic                   r_stall_timeout;
    logic [RUN_CNT_W-1:0]   w_run_cnt;
    logic [CNT_W-1:0]       w_stall_cnt;
    logic [CNT_W-1:0]       w_flush_cnt;

    localparam logic [RUN_CNT_W-1:0] TIMEOUT_PRE = RUN_CNT_W'(MAX_STALL - 1);

    // An unresolved branch cannot flush while the stage is stalled.
    assign w_hazard = bus.hazard;
    assign w_flush  = ~bus.hazard & bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = RUN;
        w_pc_wen     = 1'b1;
        w_ex_bubble  = 1'b0;
        if (w_hazard) begin
            w_next_state = STALL;
        end else if (w_flush) begin
            w_next_state = KILLED;
        end
        if (rst || w_hazard) begin
            w_pc_wen    = 1'b0;
            w_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_pc4   <= 32'h0;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (w_hazard) begin
            r_id_pc4   <= r_id_pc4;
            r_id_instr <= r_id_instr;
            r_id_valid <= r_id_valid;
        end else if (w_flush) begin
            r_id_pc4   <= bus.if_pc4;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else begin
            r_id_pc4   <= bus.if_pc4;
            r_id_instr <= bus.if_instr;
            r_id_valid <= 1'b1;
        end
    end

    // Fires on the edge that completes the MAX_STALL-th consecutive stall cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_timeout <= 1'b0;
        end else if (w_hazard && (w_run_cnt == TIMEOUT_PRE)) begin
            r_stall_timeout <= 1'b1;
        end
    end

    sat_counter #(.W(RUN_CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_hazard),
        .i_clr (~w_hazard),
        .o_cnt (w_run_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_hazard),
        .i_clr (1'b0),
        .o_cnt (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_flush),
        .i_clr (1'b0),
        .o_cnt (w_flush_cnt)
    );

    assign bus.pc_wen        = w_pc_wen;
    assign bus.ex_bubble     = w_ex_bubble;
    assign bus.id_pc4        = r_id_pc4;
    assign bus.id_instr      = r_id_instr;
    assign bus.id_valid      = r_id_valid;
    assign bus.state         = r_state;
    assign bus.stall_cnt     = w_stall_cnt;
    assign bus.flush_cnt     = w_flush_cnt;
    assign bus.stall_timeout = r_stall_timeout;
endmodule

// File: tb/tb_if_id_hold_ctrl.sv
// Directed bench: a default-width instance and a 4-bit-counter instance driven with the same stimulus.
module tb_if_id_hold_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  if_id_hold_ctrl_if #(.CNT_W(16)) bus_a ();
  if_id_hold_ctrl_if #(.CNT_W(4))  bus_b ();

  if_id_hold_ctrl #(.NOP_INSTR(32'h0), .CNT_W(16), .MAX_STALL(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  if_id_hold_ctrl #(.NOP_INSTR(32'h0), .CNT_W(4), .MAX_STALL(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic h, input logic f, input logic [31:0] pc4, input logic [31:0] instr);
    bus_a.hazard   = h;
    bus_a.flush    = f;
    bus_a.if_pc4   = pc4;
    bus_a.if_instr = instr;
    bus_b.hazard   = h;
    bus_b.flush    = f;
    bus_b.if_pc4   = pc4;
    bus_b.if_instr = instr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 32'h0000_0004, 32'h8C22_0004);

    // 1. reset
    chk("rst_pc_wen", {31'h0, bus_a.pc_wen}, 32'h0);
    chk("rst_ex_bubble", {31'h0, bus_a.ex_bubble}, 32'h1);
    chk("rst_id_instr", bus_a.id_instr, 32'h0);
    chk("rst_id_pc4", bus_a.id_pc4, 32'h0);
    chk("rst_id_valid", {31'h0, bus_a.id_valid}, 32'h0);
    chk("rst_state", {30'h0, bus_a.state}, 32'h0);
    chk("rst_stall_cnt", {16'h0, bus_a.stall_cnt}, 32'h0);
    chk("rst_flush_cnt", {16'h0, bus_a.flush_cnt}, 32'h0);
    chk("rst_timeout", {31'h0, bus_a.stall_timeout}, 32'h0);
    step();
    chk("rst_hold_instr", bus_a.id_instr, 32'h0);
    rst = 1'b0;
    #1;
    chk("run_pc_wen", {31'h0, bus_a.pc_wen}, 32'h1);
    step();
    chk("load_id_instr", bus_a.id_instr, 32'h8C22_0004);
    chk("load_id_pc4", bus_a.id_pc4, 32'h0000_0004);
    chk("load_id_valid", {31'h0, bus_a.id_valid}, 32'h1);
    chk("load_state", {30'h0, bus_a.state}, 32'h0);

    // 2. single-cycle stall
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h1111_1111);
    chk("stall_pc_wen", {31'h0, bus_a.pc_wen}, 32'h0);
    chk("stall_ex_bubble", {31'h0, bus_a.ex_bubble}, 32'h1);
    step();
    chk("stall_id_instr", bus_a.id_instr, 32'h8C22_0004);
    chk("stall_id_pc4", bus_a.id_pc4, 32'h0000_0004);
    chk("stall_cnt_1", {16'h0, bus_a.stall_cnt}, 32'h1);
    chk("stall_state", {30'h0, bus_a.state}, 32'h1);
    drive(1'b0, 1'b0, 32'h0000_0008, 32'h1111_1111);
    chk("unstall_pc_wen", {31'h0, bus_a.pc_wen}, 32'h1);
    chk("unstall_ex_bubble", {31'h0, bus_a.ex_bubble}, 32'h0);
    step();
    chk("unstall_state", {30'h0, bus_a.state}, 32'h0);
    chk("unstall_id_instr", bus_a.id_instr, 32'h1111_1111);

    // 3. flush, then consecutive flushes, then stall right after a kill
    drive(1'b0, 1'b1, 32'h0000_0100, 32'h0123_4020);
    chk("flush_pc_wen", {31'h0, bus_a.pc_wen}, 32'h1);
    chk("flush_ex_bubble", {31'h0, bus_a.ex_bubble}, 32'h0);
    step();
    chk("flush_id_instr", bus_a.id_instr, 32'h0);
    chk("flush_id_pc4", bus_a.id_pc4, 32'h0000_0100);
    chk("flush_id_valid", {31'h0, bus_a.id_valid}, 32'h0);
    chk("flush_cnt_1", {16'h0, bus_a.flush_cnt}, 32'h1);
    chk("flush_state", {30'h0, bus_a.state}, 32'h2);
    drive(1'b0, 1'b0, 32'h0000_0104, 32'h2222_2222);
    step();
    chk("post_flush_instr", bus_a.id_instr, 32'h2222_2222);
    chk("post_flush_valid", {31'h0, bus_a.id_valid}, 32'h1);
    chk("post_flush_state", {30'h0, bus_a.state}, 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0200, 32'hAAAA_0001);
    step();
    drive(1'b0, 1'b1, 32'h0000_0300, 32'hAAAA_0002);
    step();
    chk("flush2_cnt", {16'h0, bus_a.flush_cnt}, 32'h3);
    chk("flush2_id_pc4", bus_a.id_pc4, 32'h0000_0300);
    chk("flush2_state", {30'h0, bus_a.state}, 32'h2);
    drive(1'b1, 1'b0, 32'h0000_0304, 32'hBBBB_0000);
    step();
    chk("kill_stall_valid", {31'h0, bus_a.id_valid}, 32'h0);
    chk("kill_stall_instr", bus_a.id_instr, 32'h0);
    chk("kill_stall_state", {30'h0, bus_a.state}, 32'h1);
    drive(1'b0, 1'b0, 32'h0000_0304, 32'h2C01_0010);
    step();
    chk("reload_instr", bus_a.id_instr, 32'h2C01_0010);

    // 4. hazard and flush together
    drive(1'b1, 1'b1, 32'h0000_0308, 32'h3333_3333);
    chk("both_pc_wen", {31'h0, bus_a.pc_wen}, 32'h0);
    step();
    chk("both_id_instr", bus_a.id_instr, 32'h2C01_0010);
    chk("both_flush_cnt", {16'h0, bus_a.flush_cnt}, 32'h3);
    chk("both_stall_cnt", {16'h0, bus_a.stall_cnt}, 32'h3);
    chk("both_state", {30'h0, bus_a.state}, 32'h1);
    drive(1'b0, 1'b0, 32'h0000_0308, 32'h3333_3333);
    step();

    // 5. watchdog: 7-cycle run, gap, then 8-cycle run
    drive(1'b1, 1'b0, 32'h0000_030C, 32'h4444_4444);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("wd_run1", {31'h0, bus_a.stall_timeout}, 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0000_030C, 32'h4444_4444);
    step();
    chk("wd_gap", {31'h0, bus_a.stall_timeout}, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_0310, 32'h5555_5555);
    for (int i = 0; i < 7; i++) step();
    chk("wd_run2_7", {31'h0, bus_a.stall_timeout}, 32'h0);
    step();
    chk("wd_run2_8", {31'h0, bus_a.stall_timeout}, 32'h1);
    drive(1'b0, 1'b0, 32'h0000_0310, 32'h5555_5555);
    step();
    step();
    chk("wd_sticky", {31'h0, bus_a.stall_timeout}, 32'h1);
    chk("wd_stall_cnt", {16'h0, bus_a.stall_cnt}, 32'd18);
    chk("wd_stall_cnt_sat4", {28'h0, bus_b.stall_cnt}, 32'd15);

    // 6. fresh reset, 20-cycle stall, then reset mid-stall
    rst = 1'b1;
    #1;
    chk("rst2_timeout", {31'h0, bus_a.stall_timeout}, 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0400, 32'h6666_6666);
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt_b", {28'h0, bus_b.stall_cnt}, 32'd15);
    chk("sat_stall_cnt_a", {16'h0, bus_a.stall_cnt}, 32'd20);
    chk("sat_timeout_b", {31'h0, bus_b.stall_timeout}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall_cnt_b", {28'h0, bus_b.stall_cnt}, 32'h0);
    chk("mid_rst_stall_cnt_a", {16'h0, bus_a.stall_cnt}, 32'h0);
    chk("mid_rst_timeout", {31'h0, bus_b.stall_timeout}, 32'h0);
    chk("mid_rst_state", {30'h0, bus_b.state}, 32'h0);
    chk("mid_rst_pc_wen", {31'h0, bus_b.pc_wen}, 32'h0);
    drive(1'b0, 1'b0, 32'h0000_0404, 32'h7777_7777);
    rst = 1'b0;
    step();
    chk("after_rst_state", {30'h0, bus_b.state}, 32'h0);
    chk("after_rst_instr", bus_b.id_instr, 32'h7777_7777);
    chk("after_rst_valid", {31'h0, bus_b.id_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_hold_ctrl.md
# if_id_hold_ctrl

- Receiving end of the hazard/flush signals from the ID-stage hazard detector.
- Owns the IF/ID pipeline register and turns `hazard` (stall) and `flush` (branch/jump taken) into:
  - PC write-enable,
  - IF/ID hold or kill,
  - an ID/EX bubble request.
- Also keeps saturating stall/flush counters and raises a sticky watchdog flag when a stall lasts too long.
- Sits between the fetch stage and the ID stage.

## Interface

Parameters:
- `NOP_INSTR`, default 32'h0000_0000: instruction word loaded into IF/ID on flush and reset.
- `CNT_W`, default 16: width of the performance counters.
- `MAX_STALL`, default 8: number of consecutive stall cycles that sets `stall_timeout`. Range 1..255.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` input 1: rising-edge clock.
  - `rst` input 1: asynchronous, active-high reset.
- `hazard` input 1: stall request from the hazard detector.
- `flush` input 1: kill request; the branch/jump is resolved in ID.
- `if_pc4` input 32: PC+4 from fetch.
- `if_instr` input 32: instruction from fetch.
- `pc_wen` output 1: PC register write enable.
- `ex_bubble` output 1: zero ID/EX control signals this cycle.
- `id_pc4` output 32: registered PC+4.
- `id_instr` output 32: registered instruction.
- `id_valid` output 1: the ID slot holds a real instruction.
- `state` output 2: FSM state, for observability.
- `stall_cnt` output CNT_W: total stall cycles, saturating.
- `flush_cnt` output CNT_W: total flush events, saturating.
- `stall_timeout` output 1: sticky; set when a single stall run reaches MAX_STALL cycles.

## Operation

FSM states:
- RUN=2'd0: normal flow.
- STALL=2'd1: holding.
- KILLED=2'd2: the ID slot holds a flushed NOP.

Per-cycle priority: `hazard` > `flush` > normal. A stalled branch is not yet resolved, so `flush` is ignored while `hazard` is high.

- **hazard=1**
  - `pc_wen`=0 and `ex_bubble`=1, both combinational.
  - IF/ID holds `id_pc4`, `id_instr` and `id_valid`.
  - Next state is STALL.
  - The run counter increments, saturating at 255.
  - `stall_cnt` increments.
- **hazard=0, flush=1**
  - `pc_wen`=1 and `ex_bubble`=0.
  - On the edge: `id_instr`<=NOP_INSTR, `id_pc4`<=`if_pc4`, `id_valid`<=0.
  - Next state is KILLED.
  - The run counter clears.
  - `flush_cnt` increments.
- **hazard=0, flush=0**
  - `pc_wen`=1 and `ex_bubble`=0.
  - On the edge: IF/ID loads `if_pc4`/`if_instr` and `id_valid`<=1.
  - Next state is RUN.
  - The run counter clears.

Watchdog and counters:
- `stall_timeout` is set on the edge at which the run counter reaches MAX_STALL, i.e. the edge ending the MAX_STALL-th consecutive stall cycle.
- `stall_timeout` clears only on `rst`.
- Both counters saturate at all-ones and never wrap.

Transitions:
- From RUN, STALL and KILLED alike, the next state is chosen by the three rules above.
- Holding in STALL preserves whatever `id_valid` was. A stall right after a kill therefore keeps the NOP with `id_valid`=0.

## Timing

- `pc_wen` and `ex_bubble` are purely combinational from `hazard`, with zero latency.
- IF/ID outputs, `state`, counters and `stall_timeout` change only on the rising edge, or asynchronously on `rst`.
- Reset values:
  - `id_instr`=NOP_INSTR, `id_pc4`=0, `id_valid`=0.
  - `state`=RUN, counters=0, run counter=0, `stall_timeout`=0.
- While `rst`=1: `pc_wen`=0 and `ex_bubble`=1, forced.
- Reset asserted mid-stall: all registers clear immediately. After release, the first edge behaves as from RUN.
- `hazard` and `flush` high together: treated as stall; `flush_cnt` does not change.
- Flush on consecutive cycles: each one counts and each one kills.

## Structure

- Shared package `mips_pipe_pkg`:
  - state enum `hold_state_t` (RUN/STALL/KILLED),
  - constant `MIPS_NOP`=32'h0, used as the NOP_INSTR default.
- One natural sub-module, `sat_counter`, parameterised by width, with enable, async `rst` and saturate-at-max. It is instantiated for `stall_cnt`, `flush_cnt` and the 8-bit run counter.
- FSM and IF/ID register live in the top module.

## Test plan

1. **Reset.** Assert `rst` with `hazard`=0 and `if_instr`=32'h8C22_0004.
   - During reset: `pc_wen`=0, `ex_bubble`=1.
   - After release and one edge: `id_instr`=32'h8C22_0004, `id_valid`=1, `state`=0.
2. **Single-cycle stall.** Hold `hazard`=1 for one cycle, then 0.
   - `pc_wen`=0 for exactly that cycle.
   - `id_instr` is unchanged across the edge.
   - `stall_cnt`=1 and `state` goes 1 then 0.
3. **Flush.** `flush`=1 with `if_instr`=32'h0123_4020.
   - `id_instr`=NOP, `id_valid`=0, `flush_cnt`=1, `state`=2.
   - The next normal cycle loads normally.
4. **Simultaneous stall and flush.** `hazard`=1 and `flush`=1 together.
   - IF/ID holds, `flush_cnt` unchanged, `stall_cnt` increments, `state`=1.
5. **Watchdog.** With MAX_STALL=8, hold `hazard`=1 for 7 cycles, drop it, then hold it for 8 cycles.
   - `stall_timeout` stays 0 through the first run.
   - It rises after the 8th cycle of the second run and stays high until `rst`.
6. **Saturation and reset mid-stall.** Set CNT_W=4 and stall for 20 cycles.
   - `stall_cnt`=15.
   - Assert `rst` mid-stall: counters read 0 immediately, without waiting for a clock edge.
